// File: rtl/frame_strobe_writer.sv
// rtl/frame_strobe_writer.sv - column configuration frame writer driving FrameData/FrameStrobe (optional trailer check: FRAME_WRITER_CHECKSUM_EN)
module frame_strobe_writer #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows         = 7,
    parameter int NumCols         = 23
) (
    input  logic                                UserCLK,
    input  logic                                rst,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [31:0]                         s_data,
    output logic [NumRows*FrameBitsPerRow-1:0]  FrameData,
    output logic [NumCols*MaxFramesPerCol-1:0]  FrameStrobe,
    output logic                                busy,
    output logic                                err,
    output logic [15:0]                         frames_written
);

`ifdef FRAME_WRITER_CHECKSUM_EN
    localparam int DrainWords = NumRows + 1;
`else
    localparam int DrainWords = NumRows;
`endif
    localparam int CW = $clog2(DrainWords + 1);
    localparam int NS = NumCols * MaxFramesPerCol;
    localparam int IW = $clog2(NS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        DRAIN  = 3'd2,
        STROBE = 3'd3,
        GAP    = 3'd4,
        CHECK  = 3'd5
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            ready_next;
    logic            fire;
    logic            hdr_bad;
    logic            set_err;
    logic [CW-1:0]   cnt;
    logic [4:0]      col_q;
    logic [4:0]      frame_q;
    logic [IW-1:0]   strobe_idx;
    logic [NS-1:0]   strobe_vec;
`ifdef FRAME_WRITER_CHECKSUM_EN
    logic [31:0]     csum;
`endif

    assign fire    = s_valid && s_ready;
    assign busy    = (state != IDLE);
    assign hdr_bad = ({27'd0, s_data[20:16]} >= 32'(NumCols)) ||
                     ({27'd0, s_data[4:0]}   >= 32'(MaxFramesPerCol));

    // Translate the latched column/frame address into the one-hot strobe pattern.
    always_comb begin
        strobe_vec = '0;
        strobe_idx = IW'(col_q) * IW'(MaxFramesPerCol) + IW'(frame_q);
        strobe_vec[strobe_idx] = 1'b1;
    end

    // Next-state decode; ready for the next cycle is derived from the next state only.
    always_comb begin
        state_next = state;
        set_err    = 1'b0;
        case (state)
            IDLE: begin
                if (fire && s_data[31]) begin
                    if (hdr_bad) begin
                        set_err    = 1'b1;
                        state_next = DRAIN;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                if (fire && cnt == CW'(NumRows - 1)) begin
`ifdef FRAME_WRITER_CHECKSUM_EN
                    state_next = CHECK;
`else
                    state_next = STROBE;
`endif
                end
            end
            DRAIN: begin
                if (fire && cnt == CW'(DrainWords - 1)) begin
                    state_next = IDLE;
                end
            end
            CHECK: begin
`ifdef FRAME_WRITER_CHECKSUM_EN
                if (fire) begin
                    if (s_data == csum) begin
                        state_next = STROBE;
                    end else begin
                        set_err    = 1'b1;
                        state_next = IDLE;
                    end
                end
`else
                state_next = IDLE;
`endif
            end
            STROBE:  state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        ready_next = (state_next == IDLE) || (state_next == LOAD) ||
                     (state_next == DRAIN) || (state_next == CHECK);
    end

    // State register plus row capture, strobe pulse, counters and sticky error.
    always_ff @(posedge UserCLK) begin
        if (rst) begin
            state          <= IDLE;
            s_ready        <= 1'b0;
            FrameData      <= '0;
            FrameStrobe    <= '0;
            err            <= 1'b0;
            frames_written <= 16'd0;
            cnt            <= '0;
            col_q          <= 5'd0;
            frame_q        <= 5'd0;
`ifdef FRAME_WRITER_CHECKSUM_EN
            csum           <= 32'd0;
`endif
        end else begin
            state       <= state_next;
            s_ready     <= ready_next;
            err         <= err | set_err;
            FrameStrobe <= (state == STROBE) ? strobe_vec : '0;
            if (state == STROBE) begin
                frames_written <= frames_written + 16'd1;
            end
            if (fire) begin
                case (state)
                    IDLE: begin
                        if (s_data[31]) begin
                            col_q   <= s_data[20:16];
                            frame_q <= s_data[4:0];
                            cnt     <= '0;
`ifdef FRAME_WRITER_CHECKSUM_EN
                            csum    <= s_data;
`endif
                        end
                    end
                    LOAD: begin
                        for (int r = 0; r < NumRows; r++) begin
                            if (cnt == CW'(r)) begin
                                FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
                            end
                        end
                        cnt <= cnt + CW'(1);
`ifdef FRAME_WRITER_CHECKSUM_EN
                        csum <= csum ^ s_data;
`endif
                    end
                    DRAIN: begin
                        cnt <= cnt + CW'(1);
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/frame_strobe_writer.md
# frame_strobe_writer

Column-side configuration frame writer that drives the `FrameData`/`FrameStrobe` buses consumed by the fabric tiles, terminating at the per-tile strobe buffers. It accepts a stream of 32-bit configuration words over a valid/ready handshake. For each frame it captures one data word per tile row onto `FrameData`, then pulses exactly one `FrameStrobe` bit in the addressed column for one cycle. It sits between the bitstream source (UART/SPI loader) and the fabric top-level column strobe inputs.

## Interface
- `MaxFramesPerCol`, 20, frames per column (strobe bits per column)
- `FrameBitsPerRow`, 32, data bits per row word
- `NumRows`, 7, tile rows per column (data words per frame)
- `NumCols`, 23, fabric columns
- `UserCLK`  in  1  clock (only clock)
- `rst`  in  1  reset, synchronous, active-high
- `s_valid`  in  1  word valid
- `s_ready`  out  1  writer can accept word
- `s_data`  in  32  config word
- `FrameData`  out  NumRows*FrameBitsPerRow  row data; row r at bits [r*32 +: 32]
- `FrameStrobe`  out  NumCols*MaxFramesPerCol  column c, frame f at bit c*MaxFramesPerCol+f
- `busy`  out  1  high in any state other than IDLE
- `err`  out  1  sticky error flag
- `frames_written`  out  16  count of strobes issued, wraps at 16'hFFFF→0

## Operation
- Word transfer occurs on a rising edge of `UserCLK` with `s_valid && s_ready`.
- Header word: `s_data[31]`=1, column `s_data[20:16]`, frame `s_data[4:0]`. A word with `s_data[31]`=0 in IDLE is discarded silently.
- States:
  - IDLE: `s_ready`=1. A valid header goes to LOAD. A header with column ≥ NumCols or frame ≥ MaxFramesPerCol sets `err` and goes to DRAIN.
  - LOAD: `s_ready`=1. The k-th accepted word (k=0..NumRows-1) is written to row k of `FrameData`. After word NumRows-1, go to STROBE, or to CHECK when the checksum is enabled.
  - DRAIN: `s_ready`=1. Accept and discard NumRows words, or NumRows+1 with checksum, then go to IDLE. `FrameData` is unchanged.
  - STROBE: `s_ready`=0. The single addressed `FrameStrobe` bit is 1 for exactly one cycle. `frames_written` increments. Go to GAP.
  - GAP: `s_ready`=0, strobe 0, `FrameData` held. Go to IDLE.
- Data words are not inspected for bit 31 in LOAD or DRAIN.
- `FrameData` holds its last value until overwritten in LOAD. Rows not yet rewritten keep their old contents.
- `err` clears only on `rst`.
- Reset values: state IDLE, `s_ready`=0 during the reset cycle and 1 the cycle after, `FrameData`=0, `FrameStrobe`=0, `busy`=0, `err`=0, `frames_written`=0.
- Reset mid-frame aborts the frame: no strobe is issued and partial rows are cleared to 0.

## Timing
- Minimum frame on back-to-back input: 1 header + NumRows data cycles, then STROBE (1 cycle) and GAP (1 cycle).
- Strobe-to-strobe minimum: NumRows+3 cycles, or NumRows+4 with checksum.
- The strobe rises on the edge after the last row word is accepted, or after the checksum word when enabled.
- `FrameData` is stable from at least 1 cycle before the strobe until 1 cycle after it falls.
- `FrameStrobe` is registered, one-hot or zero, and never glitches.
- `s_ready` is registered and depends on state only, not on `s_valid`.

## Configuration
- Macro: `FRAME_WRITER_CHECKSUM_EN`.
- **Defined:** LOAD is followed by CHECK (`s_ready`=1), which accepts one trailer word.
  - The trailer must equal the XOR of the header and all NumRows data words.
  - On match, go to STROBE.
  - On mismatch, set `err`, issue no strobe, and go to IDLE. `FrameData` keeps the loaded rows.
  - DRAIN discards NumRows+1 words.
- **Undefined:** no CHECK state and no trailer word. Any word following the last row is treated as an IDLE word.

## Test plan
- Reset, then header col=3 frame=7 and rows 32'h0000_0001..32'h0000_0007 back-to-back → `FrameStrobe` bit 67 high for exactly 1 cycle, 8 cycles after the header is accepted; `FrameData` row 6 = 32'h7; `frames_written`=1.
- Header col=23 (invalid), then 7 words, then valid header col=0 frame=0 with 7 rows → `err`=1, first 7 words produce no strobe and `FrameData` is unchanged, then bit 0 strobes once.
- `s_valid` toggled randomly at 50% during a frame → rows land in order and one strobe is issued; `s_ready`=0 during STROBE and GAP with no word lost.
- `rst` asserted after 4 row words → next cycle `FrameData`=0, no strobe, `busy`=0; a subsequent full frame strobes normally.
- With `FRAME_WRITER_CHECKSUM_EN`: correct XOR trailer → strobe; trailer XOR 1 → no strobe, `err`=1, `frames_written` unchanged.
- 65536 minimal frames (NumRows=1 build) → `frames_written` wraps to 0 with no stuck strobe.
